control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 159 +++++++++++++++
 tb/tb_control_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle control unit for a 16-bit-instruction, 8-bit-address processor.
// Sequences FETCH/DECODE/EXEC(/MEM) and drives datapath and RAM controls.
module control_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_data,
  output logic [7:0]  ram_addr,
  output logic        ram_we,
  output logic        write_alu,
  output logic        is_load,
  output logic        alu_imm_flag,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  imm_data,
  output logic [3:0]  write_addr,
  output logic [3:0]  ra_addr,
  output logic [3:0]  rb_addr,
  output logic        write_en,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic [7:0]  pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BC   = 4'hD;
  localparam logic [3:0] OP_ADDI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] ALU_ADD = 3'd0;

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [7:0]  pc_q;
  logic        z_q, c_q;

  logic [3:0] op, rd, ra, rb;
  logic [7:0] imm8;
  logic       branch_taken;
  logic       flags_update;

  assign op   = ir_q[15:12];
  assign rd   = ir_q[11:8];
  assign ra   = ir_q[7:4];
  assign rb   = ir_q[3:0];
  assign imm8 = ir_q[7:0];

  assign branch_taken = (op == OP_JMP) || (op == OP_BZ && z_q) || (op == OP_BC && c_q);
  assign flags_update = !op[3] || (op == OP_ADDI);

  assign instr_addr = pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= 16'h0000;
      pc_q    <= RESET_PC;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        ir_q <= instr_data;
        pc_q <= pc_q + 8'd1;
      end
      // Taken branches land after the DECODE increment, so they simply overwrite pc.
      if (state_q == S_EXEC) begin
        if (branch_taken) pc_q <= imm8;
        if (flags_update) begin
          z_q <= alu_zero;
          c_q <= alu_carry;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ram_addr     = 8'h00;
    ram_we       = 1'b0;
    write_alu    = 1'b0;
    is_load      = 1'b0;
    alu_imm_flag = 1'b0;
    alu_opcode   = 3'd0;
    imm_data     = 8'h00;
    write_addr   = 4'h0;
    ra_addr      = 4'h0;
    rb_addr      = 4'h0;
    write_en     = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (!op[3]) begin
          write_en   = 1'b1;
          write_alu  = 1'b1;
          alu_opcode = op[2:0];
          write_addr = rd;
          ra_addr    = ra;
          rb_addr    = rb;
        end else begin
          case (op)
            OP_LDI: begin
              write_en   = 1'b1;
              imm_data   = imm8;
              write_addr = rd;
            end
            OP_LD: begin
              ram_addr = imm8;
              state_d  = S_MEM;
            end
            OP_ST: begin
              ram_we   = 1'b1;
              ram_addr = imm8;
              ra_addr  = rd;
            end
            OP_ADDI: begin
              write_en     = 1'b1;
              write_alu    = 1'b1;
              alu_imm_flag = 1'b1;
              alu_opcode   = ALU_ADD;
              ra_addr      = rd;
              write_addr   = rd;
              imm_data     = imm8;
            end
            OP_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        state_d    = S_FETCH;
        ram_addr   = imm8;
        is_load    = 1'b1;
        write_en   = 1'b1;
        write_addr = rd;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level ISA model predicts every cycle's
// outputs into a queue, which is compared against the DUT each cycle.
module tb_control_unit;

  localparam logic [7:0] RESET_PC = 8'h00;
  localparam int W = 53;

  typedef struct packed {
    logic [7:0] instr_addr;
    logic [7:0] pc;
    logic       halted;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic       write_alu;
    logic       is_load;
    logic       alu_imm_flag;
    logic [2:0] alu_opcode;
    logic [7:0] imm_data;
    logic [3:0] write_addr;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;
    logic       write_en;
  } obs_t;

  logic        clk, rst_n;
  logic [7:0]  instr_addr, ram_addr, imm_data, pc;
  logic [15:0] instr_data;
  logic        ram_we, write_alu, is_load, alu_imm_flag, write_en, halted;
  logic [2:0]  alu_opcode;
  logic [3:0]  write_addr, ra_addr, rb_addr;
  logic        alu_zero, alu_carry;

  logic [15:0] rom [256];
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  obs_t         cur;
  int           errors = 0;
  int           checks = 0;

  // model architectural state
  logic [7:0] m_pc;
  logic       m_z, m_c;

  control_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr_data(instr_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .write_alu(write_alu), .is_load(is_load),
    .alu_imm_flag(alu_imm_flag), .alu_opcode(alu_opcode), .imm_data(imm_data),
    .write_addr(write_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .write_en(write_en),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .pc(pc), .halted(halted)
  );

  // clock / reset / synchronous ROM
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= rom[instr_addr];

  always_comb begin
    cur = '0;
    cur.instr_addr   = instr_addr;
    cur.pc           = pc;
    cur.halted       = halted;
    cur.ram_addr     = ram_addr;
    cur.ram_we       = ram_we;
    cur.write_alu    = write_alu;
    cur.is_load      = is_load;
    cur.alu_imm_flag = alu_imm_flag;
    cur.alu_opcode   = alu_opcode;
    cur.imm_data     = imm_data;
    cur.write_addr   = write_addr;
    cur.ra_addr      = ra_addr;
    cur.rb_addr      = rb_addr;
    cur.write_en     = write_en;
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic obs_t idle_obs(input logic [7:0] p);
    obs_t e;
    e = '0;
    e.instr_addr = p;
    e.pc = p;
    return e;
  endfunction

  // Reference model: one whole instruction per call, following the ISA table.
  task automatic model_instr(input logic fz, input logic fc, input int halt_cycles);
    logic [15:0] ins;
    logic [3:0]  op, rd, ra, rb;
    logic [7:0]  imm, nxt;
    obs_t        e, m;
    ins = rom[m_pc];
    op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0]; imm = ins[7:0];
    e = idle_obs(m_pc);
    exp_q.push_back(e); tag_q.push_back("fetch");
    exp_q.push_back(e); tag_q.push_back("decode");
    nxt = m_pc + 8'd1;
    e = idle_obs(nxt);
    m = idle_obs(nxt);
    if (op < 4'h8) begin
      e.write_en = 1; e.write_alu = 1; e.alu_opcode = op[2:0];
      e.write_addr = rd; e.ra_addr = ra; e.rb_addr = rb;
      m_z = fz; m_c = fc;
    end else if (op == 4'h8) begin
      e.write_en = 1; e.imm_data = imm; e.write_addr = rd;
    end else if (op == 4'h9) begin
      e.ram_addr = imm;
      m.ram_addr = imm; m.is_load = 1; m.write_en = 1; m.write_addr = rd;
    end else if (op == 4'hA) begin
      e.ram_we = 1; e.ram_addr = imm; e.ra_addr = rd;
    end else if (op == 4'hB) begin
      nxt = imm;
    end else if (op == 4'hC) begin
      if (m_z) nxt = imm;
    end else if (op == 4'hD) begin
      if (m_c) nxt = imm;
    end else if (op == 4'hE) begin
      e.write_en = 1; e.write_alu = 1; e.alu_imm_flag = 1; e.alu_opcode = 3'd0;
      e.ra_addr = rd; e.write_addr = rd; e.imm_data = imm;
      m_z = fz; m_c = fc;
    end
    exp_q.push_back(e); tag_q.push_back("exec");
    if (op == 4'h9) begin
      exp_q.push_back(m); tag_q.push_back("mem");
    end
    if (op == 4'hF) begin
      m.halted = 1;
      for (int i = 0; i < halt_cycles; i++) begin
        exp_q.push_back(m); tag_q.push_back("halt");
      end
    end
    m_pc = nxt;
  endtask

  // driver: called at a negedge, checks each predicted cycle in turn
  task automatic run_instr(input logic fz, input logic fc, input int halt_cycles);
    model_instr(fz, fc, halt_cycles);
    alu_zero  = fz;
    alu_carry = fc;
    while (exp_q.size() > 0) begin
      check(tag_q.pop_front(), cur, exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset", cur, idle_obs(RESET_PC));
    repeat (2) @(negedge clk);
    check("reset_hold", cur, idle_obs(RESET_PC));
    rst_n = 1'b1;
    m_pc = RESET_PC; m_z = 1'b0; m_c = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h8000;
  endtask

  initial begin
    rst_n = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
    clear_rom();
    // directed program: ALU sequence, LD, ST, branches, JMP to 0xFF wrap
    rom[8'h00] = 16'h8301; rom[8'h01] = 16'h8402; rom[8'h02] = 16'h0534;
    rom[8'h03] = 16'h9720; rom[8'h04] = 16'hA2F0; rom[8'h05] = 16'h0123;
    rom[8'h06] = 16'hC010; rom[8'h10] = 16'h1234; rom[8'h11] = 16'hC040;
    rom[8'h12] = 16'hE305; rom[8'h13] = 16'hD0FE; rom[8'hFE] = 16'hB0FF;
    rom[8'hFF] = 16'h8155;
    @(negedge clk);
    do_reset();
    run_instr(0, 0, 0); run_instr(0, 0, 0); run_instr(0, 1, 0);
    run_instr(1, 1, 0); run_instr(0, 0, 0);
    run_instr(1, 0, 0); run_instr(0, 0, 0);
    run_instr(0, 0, 0); run_instr(0, 0, 0);
    run_instr(0, 1, 0); run_instr(0, 0, 0);
    run_instr(0, 0, 0); run_instr(0, 0, 0);
    check("wrap_pc", {45'd0, pc}, {45'd0, 8'h00});

    // HALT holds for many cycles, then a reset pulse restarts at RESET_PC
    clear_rom();
    rom[8'h00] = 16'h8105; rom[8'h01] = 16'hF000;
    do_reset();
    run_instr(0, 0, 0);
    run_instr(1, 1, 24);
    do_reset();
    run_instr(0, 0, 0);

    // reset asserted during EXEC of LDI aborts the write
    rom[8'h00] = 16'h8AAB;
    do_reset();
    model_instr(0, 0, 0);
    check(tag_q.pop_front(), cur, exp_q.pop_front());
    @(negedge clk);
    check(tag_q.pop_front(), cur, exp_q.pop_front());
    exp_q.delete(); tag_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_exec", cur, idle_obs(RESET_PC));
    @(negedge clk);
    do_reset();
    run_instr(0, 0, 0);

    // randomized programs without HALT
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++)
        rom[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      do_reset();
      for (int n = 0; n < 150; n++)
        run_instr(1'($urandom), 1'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
